// File: rtl/pixel_pkg.sv
// Shared constants for the pixel pair packer: default widths, pixels per pair
// and the control state encoding.
package pixel_pkg;

  localparam int PIX_W_DEF = 10;
  localparam int CNT_W_DEF = 12;
  localparam int PIX_PAIR  = 2;

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_SKIP   = 2'd3;

endpackage

// File: rtl/pixel_pair_packer_if.sv
// Per-cycle event bus from the packer control path to the line/frame statistics block.
interface pixel_pair_packer_if;
  import pixel_pkg::*;

  logic frame_start;
  logic sample;
  logic line_rise;
  logic line_fall;
  logic frame_end;

  modport master (output frame_start, sample, line_rise, line_fall, frame_end);
  modport slave  (input  frame_start, sample, line_rise, line_fall, frame_end);

endinterface

// File: rtl/pixel_line_stats.sv
// Pixel-per-line, line-per-frame and completed-frame counters plus the sticky odd-line flag.
module pixel_line_stats
  import pixel_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_pair_packer_if.slave   ev,
  output logic [CNT_W-1:0]     line_len_o,
  output logic [CNT_W-1:0]     line_count_o,
  output logic [15:0]          frame_count_o,
  output logic                 odd_err_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic [CNT_W-1:0] line_len_q, line_len_d;
  logic [CNT_W-1:0] line_count_q, line_count_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             odd_err_q, odd_err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    lines_d       = lines_q;
    line_len_d    = line_len_q;
    line_count_d  = line_count_q;
    frame_count_d = frame_count_q;
    odd_err_d     = odd_err_q;

    if (ev.sample)
      pix_cnt_d = ev.line_rise ? CNT_ONE : sat_inc(pix_cnt_q);

    // A line that starts on the very first accepted cycle is counted immediately.
    if (ev.frame_start)
      lines_d = ev.line_rise ? CNT_ONE : '0;
    else if (ev.line_rise)
      lines_d = sat_inc(lines_q);

    if (ev.frame_start)
      odd_err_d = 1'b0;
    else if (ev.line_fall) begin
      line_len_d = pix_cnt_q;
      if (pix_cnt_q[0])
        odd_err_d = 1'b1;
    end

    if (ev.frame_end) begin
      line_count_d  = lines_q;
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q     <= '0;
      lines_q       <= '0;
      line_len_q    <= '0;
      line_count_q  <= '0;
      frame_count_q <= '0;
      odd_err_q     <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      lines_q       <= lines_d;
      line_len_q    <= line_len_d;
      line_count_q  <= line_count_d;
      frame_count_q <= frame_count_d;
      odd_err_q     <= odd_err_d;
    end
  end

  assign line_len_o    = line_len_q;
  assign line_count_o  = line_count_q;
  assign frame_count_o = frame_count_q;
  assign odd_err_o     = odd_err_q;

endmodule

// File: rtl/pixel_pair_packer.sv
// Packs camera pixels into {second, first} pairs for accepted frames.
// Optional PIX_TEST_PATTERN_EN adds test_mode, replacing pixels with their in-line index.
//
// state  | meaning
// SYNC   | after reset; wait for cam_fval low so a partial frame is never used
// IDLE   | between frames; enable sampled at the cam_fval rise
// ACTIVE | accepted frame in flight; pixels paired and counted
// SKIP   | rejected frame; all outputs held quiet until cam_fval falls
module pixel_pair_packer
  import pixel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PIX_W-1:0]          cam_pixel,
  input  logic                      cam_fval,
  input  logic                      cam_lval,
  input  logic                      enable,
`ifdef PIX_TEST_PATTERN_EN
  input  logic                      test_mode,
`endif
  output logic [PIX_PAIR*PIX_W-1:0] pixel_data,
  output logic                      frame_valid,
  output logic                      line_valid,
  output logic [15:0]               frame_count,
  output logic [CNT_W-1:0]          line_count,
  output logic [CNT_W-1:0]          line_len,
  output logic                      odd_line_err
);

  logic [1:0]                state_q, state_d;
  logic                      lval_q;
  logic                      fval_d1_q;
  logic                      fv_q, fv_d;
  logic                      lv_q, lv_d;
  logic                      slot_b_q, slot_b_d, slot_b_now;
  logic [PIX_W-1:0]          pix_a_q, pix_a_d;
  logic [PIX_PAIR*PIX_W-1:0] pair_q, pair_d;
  logic [PIX_W-1:0]          pix_in;

  logic line_act, frame_start, in_frame, sample, line_rise, line_fall, frame_end;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:           if (!cam_fval) state_d = ST_IDLE;
      ST_IDLE:           if (cam_fval)  state_d = enable ? ST_ACTIVE : ST_SKIP;
      ST_ACTIVE, ST_SKIP: if (!cam_fval) state_d = ST_IDLE;
      default:           state_d = ST_SYNC;
    endcase
  end

  // The frame-start cycle already counts as accepted so a line beginning with cam_fval is not lost.
  assign line_act    = cam_fval & cam_lval;
  assign frame_start = (state_q == ST_IDLE) & cam_fval & enable;
  assign in_frame    = (state_q == ST_ACTIVE) | frame_start;
  assign sample      = in_frame & line_act;
  assign line_rise   = sample & ~lval_q;
  assign line_fall   = in_frame & lval_q & ~line_act;
  assign frame_end   = (state_q == ST_ACTIVE) & ~cam_fval;

`ifdef PIX_TEST_PATTERN_EN
  localparam logic [PIX_W-1:0] PAT_ONE = {{(PIX_W-1){1'b0}}, 1'b1};

  logic             test_q, test_now;
  logic [PIX_W-1:0] pat_q, pat_d, pat_idx;

  always_comb begin
    test_now = frame_start ? test_mode : test_q;
    pat_idx  = line_rise ? '0 : pat_q;
    pat_d    = sample ? pat_idx + PAT_ONE : pat_q;
    pix_in   = test_now ? pat_idx : cam_pixel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      test_q <= 1'b0;
      pat_q  <= '0;
    end else begin
      test_q <= test_now;
      pat_q  <= pat_d;
    end
  end
`else
  assign pix_in = cam_pixel;
`endif

  // A trailing unpaired slot-A pixel is simply overwritten at the next line start.
  always_comb begin
    slot_b_now = slot_b_q & ~line_rise;
    slot_b_d   = slot_b_q;
    pix_a_d    = pix_a_q;
    pair_d     = pair_q;
    lv_d       = 1'b0;
    if (sample) begin
      if (slot_b_now) begin
        pair_d   = {pix_in, pix_a_q};
        lv_d     = 1'b1;
        slot_b_d = 1'b0;
      end else begin
        pix_a_d  = pix_in;
        slot_b_d = 1'b1;
      end
    end
  end

  assign fv_d = fval_d1_q & (state_q == ST_ACTIVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SYNC;
      lval_q    <= 1'b0;
      fval_d1_q <= 1'b0;
      fv_q      <= 1'b0;
      lv_q      <= 1'b0;
      slot_b_q  <= 1'b0;
      pix_a_q   <= '0;
      pair_q    <= '0;
    end else begin
      state_q   <= state_d;
      lval_q    <= line_act;
      fval_d1_q <= cam_fval;
      fv_q      <= fv_d;
      lv_q      <= lv_d;
      slot_b_q  <= slot_b_d;
      pix_a_q   <= pix_a_d;
      pair_q    <= pair_d;
    end
  end

  pixel_pair_packer_if ev ();

  assign ev.frame_start = frame_start;
  assign ev.sample      = sample;
  assign ev.line_rise   = line_rise;
  assign ev.line_fall   = line_fall;
  assign ev.frame_end   = frame_end;

  pixel_line_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk           (clk),
    .rst_n         (reset),
    .ev            (ev.slave),
    .line_len_o    (line_len),
    .line_count_o  (line_count),
    .frame_count_o (frame_count),
    .odd_err_o     (odd_line_err)
  );

  assign pixel_data  = pair_q;
  assign frame_valid = fv_q;
  assign line_valid  = lv_q;

endmodule

// File: tb/tb_pixel_pair_packer.sv
// Directed, table-driven bench for pixel_pair_packer; the test-pattern case runs
// only when PIX_TEST_PATTERN_EN is defined.
module tb_pixel_pair_packer;

  logic        clk;
  logic        reset;
  logic [9:0]  cam_pixel;
  logic        cam_fval;
  logic        cam_lval;
  logic        enable;
`ifdef PIX_TEST_PATTERN_EN
  logic        test_mode;
`endif
  logic [19:0] pixel_data;
  logic        frame_valid;
  logic        line_valid;
  logic [15:0] frame_count;
  logic [11:0] line_count;
  logic [11:0] line_len;
  logic        odd_line_err;

  pixel_pair_packer dut (
    .clk          (clk),
    .reset        (reset),
    .cam_pixel    (cam_pixel),
    .cam_fval     (cam_fval),
    .cam_lval     (cam_lval),
    .enable       (enable),
`ifdef PIX_TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .pixel_data   (pixel_data),
    .frame_valid  (frame_valid),
    .line_valid   (line_valid),
    .frame_count  (frame_count),
    .line_count   (line_count),
    .line_len     (line_len),
    .odd_line_err (odd_line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fval;
    logic        lval;
    logic [9:0]  pix;
    logic        exp_lv;
    logic        exp_fv;
    logic [19:0] exp_data;
  } vec_t;

  vec_t        tbl[12];
  int          tests = 0;
  int          fails = 0;
  logic [19:0] pairs[$];
  logic        fv_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (line_valid === 1'b1) pairs.push_back(pixel_data);
    if (frame_valid === 1'b1) fv_seen = 1'b1;
  endtask

  task automatic drive(input logic f, input logic l, input logic [9:0] p);
    cam_fval  = f;
    cam_lval  = l;
    cam_pixel = p;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 10'h0);
  endtask

  task automatic check_pairs(input string name, input logic [19:0] exp[$]);
    check({name, "_count"}, pairs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < pairs.size()) ? pairs[i] : 20'hFFFFF, exp[i]);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 20'h00000};
    tbl[1]  = '{1'b1, 1'b1, 10'd1, 1'b0, 1'b1, 20'h00000};
    tbl[2]  = '{1'b1, 1'b1, 10'd2, 1'b1, 1'b1, 20'h00801};
    tbl[3]  = '{1'b1, 1'b1, 10'd3, 1'b0, 1'b1, 20'h00801};
    tbl[4]  = '{1'b1, 1'b1, 10'd4, 1'b1, 1'b1, 20'h01003};
    tbl[5]  = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 20'h01003};
    tbl[6]  = '{1'b1, 1'b1, 10'd1, 1'b0, 1'b1, 20'h01003};
    tbl[7]  = '{1'b1, 1'b1, 10'd2, 1'b1, 1'b1, 20'h00801};
    tbl[8]  = '{1'b1, 1'b1, 10'd3, 1'b0, 1'b1, 20'h00801};
    tbl[9]  = '{1'b1, 1'b1, 10'd4, 1'b1, 1'b1, 20'h01003};
    tbl[10] = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 20'h01003};
    tbl[11] = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 20'h01003};

    reset     = 1'b0;
    cam_pixel = '0;
    cam_fval  = 1'b0;
    cam_lval  = 1'b0;
    enable    = 1'b0;
    fv_seen   = 1'b0;
`ifdef PIX_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_data", pixel_data, 20'h0);
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_frame_count", frame_count, 16'h0);
    check("rst_line_count", line_count, 12'h0);
    check("rst_line_len", line_len, 12'h0);
    check("rst_odd_err", odd_line_err, 1'b0);
    reset = 1'b1;
    idle(3);

    // Two lines of 1,2,3,4; both levels fall together after the last pixel.
    enable = 1'b1;
    pairs.delete();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].fval, tbl[i].lval, tbl[i].pix);
      check($sformatf("t1_lv_%0d", i), line_valid, tbl[i].exp_lv);
      check($sformatf("t1_fv_%0d", i), frame_valid, tbl[i].exp_fv);
      check($sformatf("t1_data_%0d", i), pixel_data, tbl[i].exp_data);
    end
    check("t1_pulses", pairs.size(), 4);
    check("t1_frame_count", frame_count, 16'd1);
    check("t1_line_count", line_count, 12'd2);
    check("t1_line_len", line_len, 12'd4);
    check("t1_odd_err", odd_line_err, 1'b0);

    // Odd-length line: trailing pixel dropped, sticky error flag.
    idle(2);
    pairs.delete();
    drive(1'b1, 1'b0, 10'h0);
    for (int p = 5; p <= 9; p++) drive(1'b1, 1'b1, 10'(p));
    drive(1'b1, 1'b0, 10'h0);
    check("t2_odd_err_set", odd_line_err, 1'b1);
    check("t2_line_len", line_len, 12'd5);
    idle(2);
    check_pairs("t2_pair", '{20'h01805, 20'h02007});
    check("t2_data_held", pixel_data, 20'h02007);
    check("t2_frame_count", frame_count, 16'd2);
    check("t2_line_count", line_count, 12'd1);
    check("t2_odd_err_sticky", odd_line_err, 1'b1);

    // Next frame clears the flag; last pair must still see frame_valid.
    pairs.delete();
    drive(1'b1, 1'b0, 10'h0);
    check("t3_odd_err_clear", odd_line_err, 1'b0);
    drive(1'b1, 1'b1, 10'h3FF);
    drive(1'b1, 1'b1, 10'h001);
    check("t3_lv_fv_last_pair", {line_valid, frame_valid}, 2'b11);
    drive(1'b0, 1'b0, 10'h0);
    check("t3_fv_after_fall", frame_valid, 1'b1);
    idle(2);
    check_pairs("t3_pair", '{20'h007FF});
    check("t3_frame_count", frame_count, 16'd3);
    check("t3_line_len", line_len, 12'd2);

    // Frame rejected at its start; enable rising mid-frame has no effect.
    idle(2);
    pairs.delete();
    fv_seen = 1'b0;
    enable  = 1'b0;
    drive(1'b1, 1'b0, 10'h0);
    enable = 1'b1;
    for (int p = 1; p <= 4; p++) drive(1'b1, 1'b1, 10'(p));
    drive(1'b1, 1'b0, 10'h0);
    idle(3);
    check("t4_pairs", pairs.size(), 0);
    check("t4_fv_seen", fv_seen, 1'b0);
    check("t4_frame_count", frame_count, 16'd3);
    check("t4_data_held", pixel_data, 20'h007FF);

    // Line-valid pulse outside a frame is ignored.
    drive(1'b0, 1'b1, 10'h155);
    drive(1'b0, 1'b1, 10'h0AA);
    drive(1'b0, 1'b1, 10'h155);
    idle(2);
    check("t5_pairs", pairs.size(), 0);
    check("t5_line_len", line_len, 12'd2);

    // Reset mid-frame, released while cam_fval is still high.
    drive(1'b1, 1'b0, 10'h0);
    drive(1'b1, 1'b1, 10'h001);
    drive(1'b1, 1'b1, 10'h002);
    check("t6_pre_rst_lv_fv", {line_valid, frame_valid}, 2'b11);
    reset = 1'b0;
    #1;
    check("t6_rst_fv", frame_valid, 1'b0);
    check("t6_rst_lv", line_valid, 1'b0);
    check("t6_rst_data", pixel_data, 20'h0);
    check("t6_rst_frame_count", frame_count, 16'h0);
    check("t6_rst_line_len", line_len, 12'h0);
    drive(1'b1, 1'b1, 10'h003);
    drive(1'b1, 1'b1, 10'h004);
    reset = 1'b1;
    pairs.delete();
    fv_seen = 1'b0;
    drive(1'b1, 1'b1, 10'h001);
    drive(1'b1, 1'b1, 10'h002);
    drive(1'b1, 1'b0, 10'h0);
    drive(1'b1, 1'b1, 10'h003);
    drive(1'b1, 1'b1, 10'h004);
    idle(3);
    check("t6_partial_pairs", pairs.size(), 0);
    check("t6_partial_fv", fv_seen, 1'b0);
    check("t6_partial_frame_count", frame_count, 16'd0);
    drive(1'b1, 1'b0, 10'h0);
    drive(1'b1, 1'b1, 10'h00A);
    drive(1'b1, 1'b1, 10'h00B);
    drive(1'b1, 1'b0, 10'h0);
    idle(2);
    check_pairs("t6_next_pair", '{20'h02C0A});
    check("t6_next_frame_count", frame_count, 16'd1);
    check("t6_next_line_count", line_count, 12'd1);

    // One-cycle frame with no lines still counts.
    drive(1'b1, 1'b0, 10'h0);
    idle(2);
    check("t7_frame_count", frame_count, 16'd2);
    check("t7_line_count", line_count, 12'd0);

`ifdef PIX_TEST_PATTERN_EN
    pairs.delete();
    test_mode = 1'b1;
    drive(1'b1, 1'b0, 10'h0);
    test_mode = 1'b0;
    for (int p = 0; p < 6; p++) drive(1'b1, 1'b1, 10'h3FF);
    drive(1'b1, 1'b0, 10'h0);
    idle(2);
    check_pairs("t8_pattern", '{20'h00400, 20'h00C02, 20'h01404});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_pair_packer.md
PIXEL_PAIR_PACKER -- requirements
Module: pixel_pair_packer

Interface
REQ-001 SHALL have parameter PIX_W, default 10, the camera pixel width in bits.
REQ-002 SHALL have parameter CNT_W, default 12, the width of the line and pixel counters.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cam_pixel, input, PIX_W, the camera pixel sampled on each rising clk edge.
REQ-006 SHALL have port cam_fval, input, 1, the camera frame-valid level.
REQ-007 SHALL have port cam_lval, input, 1, the camera line-valid level.
REQ-008 SHALL have port enable, input, 1, frame acceptance enable, sampled only at frame start.
REQ-009 SHALL have port pixel_data, output, 2*PIX_W, carrying {second pixel, first pixel} of a pair.
REQ-010 SHALL have port frame_valid, output, 1, high while an accepted frame is in flight.
REQ-011 SHALL have port line_valid, output, 1, a one-cycle strobe marking a valid pixel_data pair.
REQ-012 SHALL have port frame_count, output, 16, the number of accepted frames completed (wraps).
REQ-013 SHALL have port line_count, output, CNT_W, the number of lines in the last completed frame.
REQ-014 SHALL have port line_len, output, CNT_W, the pixel count of the most recent line.
REQ-015 SHALL have port odd_line_err, output, 1, sticky per frame, set when a line has an odd pixel count.

Function
REQ-016 SHALL implement states SYNC, IDLE, ACTIVE and SKIP, entering SYNC on reset.
REQ-017 SHALL transition SYNC->IDLE on a cycle where cam_fval=0.
REQ-018 SHALL, in IDLE, on cam_fval=1, go to ACTIVE if enable=1, else to SKIP.
REQ-019 SHALL transition ACTIVE->IDLE and SKIP->IDLE on cam_fval=0.
REQ-020 SHALL, in ACTIVE, sample a pixel on each cycle where cam_fval&cam_lval=1.
REQ-021 SHALL alternate samples within a line between slot A and slot B, resetting to slot A at each cam_lval rise.
REQ-022 SHALL, on a slot-B sample, register pixel_data={B,A} and pulse line_valid the next cycle.
REQ-023 SHALL hold pixel_data between pulses.
REQ-024 SHALL drive frame_valid as cam_fval delayed two clocks, gated by the ACTIVE state of the frame.
REQ-025 SHALL cover the final pair with frame_valid even when cam_fval and cam_lval fall together.
REQ-026 SHALL keep frame_valid and line_valid at 0 for SKIP and SYNC frames.
REQ-027 SHALL never emit a pair for the trailing pixel of an odd-length line: discard it and set odd_line_err.
REQ-028 SHALL clear odd_line_err on entry to ACTIVE.
REQ-029 SHALL load line_len with the pixel count on each cam_lval fall in ACTIVE.
REQ-030 SHALL saturate the pixel and line counters at all-ones.
REQ-031 SHALL, on ACTIVE->IDLE, load line_count and increment frame_count modulo 2^16.
REQ-032 SHALL ignore a cam_lval pulse while cam_fval=0.
REQ-033 SHALL treat a frame at least one cycle long with zero lines as valid: frame_count increments and line_count=0.

Reset
REQ-034 SHALL set pixel_data, line_valid, frame_valid, frame_count, line_count, line_len and odd_line_err to 0 during reset.
REQ-035 SHALL, on reset asserted mid-frame, drop all output immediately, and on release discard the partial frame via SYNC.

Configuration
REQ-036 SHALL, with PIX_TEST_PATTERN_EN defined, add an input test_mode of width 1, sampled at IDLE->ACTIVE.
REQ-037 SHALL, with PIX_TEST_PATTERN_EN defined and test_mode=1, replace each pixel with (pixel index within line) mod 2^PIX_W, starting at 0.
REQ-038 SHALL, without PIX_TEST_PATTERN_EN, omit the test_mode port and pass camera data unchanged.

Structure
REQ-039 SHALL take the PIX_W default, the pair-width constant and the state enumeration from shared package pixel_pkg.
REQ-040 SHALL place the line-length, line-count and frame-count counters in the single sub-module pixel_line_stats.

Verification
REQ-041 SHALL cover: enable=1, 1 frame, 2 lines of 4 pixels 1,2,3,4 -> 4 line_valid pulses, pixel_data 0x00801 then 0x01003, frame_count=1, line_count=2, line_len=4.
REQ-042 SHALL cover: a line of 5 pixels -> 2 pairs, odd_line_err=1, line_len=5; the next frame clears odd_line_err.
REQ-043 SHALL cover: enable=0 at the cam_fval rise, toggled to 1 mid-frame -> no outputs and frame_count unchanged.
REQ-044 SHALL cover: reset released with cam_fval=1 -> that frame ignored and the next frame accepted.
REQ-045 SHALL cover: cam_fval and cam_lval falling together after the last pixel -> the final line_valid pulse occurs while frame_valid=1.
REQ-046 SHALL cover: with PIX_TEST_PATTERN_EN and test_mode=1, 6-pixel line -> pixel_data 0x00400, 0x00C02, 0x01404.
